// File: rtl/inst_issue_ctrl.sv
// inst_issue_ctrl: feeds instruction words to the cpu core.
//   Source words are buffered in a DEPTH-entry FIFO, with a tag that marks the last word.
//   While running, the head word is issued to the core on every non-stalled edge.
//   If the FIFO is empty, a NOP bubble is issued instead.
//   After the last word, DRAIN_CYCLES NOPs drain the core's pipeline.
//   An ecall from the core halts issue at once and flushes the FIFO.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_start                    level run request (IDLE->RUN, low returns DONE/HALT->IDLE)
//   i_src_valid/inst/last      source word handshake, o_src_ready accepts
//   i_cpu_stall, i_ecall_ready core status
//   o_cpu_start, o_cpu_inst    core controls (o_cpu_inst registered)
//   o_done, o_halted           finished / finished by ecall
//   o_issue_cnt                real instructions issued (wraps)
module inst_issue_ctrl #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_src_valid,
  input  logic [31:0] i_src_inst,
  input  logic        i_src_last,
  output logic        o_src_ready,
  input  logic        i_cpu_stall,
  input  logic        i_ecall_ready,
  output logic        o_cpu_start,
  output logic [31:0] o_cpu_inst,
  output logic        o_done,
  output logic        o_halted,
  output logic [15:0] o_issue_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_HALT} state_t;
  typedef struct packed {
    logic        last;
    logic [31:0] inst;
  } entry_t;

  state_t         state, state_nx;
  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           last_seen;
  logic [DCW-1:0] drain_cnt;
  logic [31:0]    cpu_inst, inst_nx;
  logic [15:0]    issue_cnt;
  logic           full, empty, push, pop, flush, drain_clr, drain_inc;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Ready uses only registered state, so it reflects occupancy before any pop on this edge.
  assign o_src_ready = !full && !last_seen && (state == S_IDLE || state == S_RUN);
  assign push        = i_src_valid && o_src_ready;

  always_comb begin
    state_nx  = state;
    inst_nx   = cpu_inst;
    pop       = 1'b0;
    flush     = 1'b0;
    drain_clr = 1'b0;
    drain_inc = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nx = S_RUN;
      S_RUN: begin
        // Ecall wins over popping, even over a pop of the last word.
        if (i_ecall_ready) begin
          state_nx = S_HALT;
          flush    = 1'b1;
          inst_nx  = NOP_INST;
        end else if (!i_cpu_stall) begin
          if (!empty) begin
            pop     = 1'b1;
            inst_nx = head.inst;
            if (head.last) begin
              state_nx  = S_DRAIN;
              drain_clr = 1'b1;
            end
          end else begin
            inst_nx = NOP_INST;
          end
        end
      end
      S_DRAIN: begin
        if (i_ecall_ready) begin
          state_nx = S_HALT;
          flush    = 1'b1;
          inst_nx  = NOP_INST;
        end else if (!i_cpu_stall) begin
          inst_nx = NOP_INST;
          if (drain_cnt == DCW'(DRAIN_CYCLES)) state_nx = S_DONE;
          else                                 drain_inc = 1'b1;
        end
      end
      // o_cpu_inst is already NOP in these states, so it simply holds.
      S_DONE, S_HALT: if (!i_start) begin
        state_nx = S_IDLE;
        flush    = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_seen <= 1'b0;
      drain_cnt <= '0;
      cpu_inst  <= NOP_INST;
      issue_cnt <= '0;
    end else begin
      state    <= state_nx;
      cpu_inst <= inst_nx;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        last_seen <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && i_src_last) last_seen <= 1'b1;
      end
      if (pop)            issue_cnt <= issue_cnt + 16'd1;
      if (drain_clr)      drain_cnt <= '0;
      else if (drain_inc) drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Storage is not reset: pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{last: i_src_last, inst: i_src_inst};
  end

  assign o_cpu_inst  = cpu_inst;
  assign o_issue_cnt = issue_cnt;
  assign o_cpu_start = (state == S_RUN) || (state == S_DRAIN);
  assign o_done      = (state == S_DONE) || (state == S_HALT);
  assign o_halted    = (state == S_HALT);
endmodule
